// File: rtl/tone_player_if.sv
// tone_player_if: control and audio signals between a note sequencer and
// tone_player.
//   master : sequencer side, drives start/stop/note/octave/duration and
//            observes speaker/busy/done
//   slave  : tone_player side
// Signals:
//   start    - one-cycle request to play a note (taken only when idle)
//   stop     - abort the note in progress and its trailing gap
//   note     - 0 = rest, 1..12 = C..B, 13..15 = rest
//   octave   - right shift applied to the base half-period
//   duration - note length in ticks
//   speaker  - square-wave audio output
//   busy     - high while a note or its gap is in progress
//   done     - one-cycle pulse when a note and its gap finish normally
interface tone_player_if #(
  parameter int DUR_W = 16
) ();
  logic             start;
  logic             stop;
  logic [3:0]       note;
  logic [2:0]       octave;
  logic [DUR_W-1:0] duration;
  logic             speaker;
  logic             busy;
  logic             done;

  modport master (
    output start, stop, note, octave, duration,
    input  speaker, busy, done
  );

  modport slave (
    input  start, stop, note, octave, duration,
    output speaker, busy, done
  );
endinterface

// File: rtl/tone_player.sv
// tone_player: plays one square-wave note, then a fixed silent gap.
// Ports:
//   clk - system clock (50 MHz nominal)
//   rst - asynchronous active-high reset
//   bus - tone_player_if.slave: start/stop/note/octave/duration in,
//         speaker/busy/done out (all outputs registered)
// Parameters:
//   DUR_W     - width of the duration input, in ticks
//   TICK_CLKS - clocks per duration tick
//   GAP_TICKS - silent ticks after every note
module tone_player #(
  parameter int DUR_W     = 16,
  parameter int TICK_CLKS = 50000,
  parameter int GAP_TICKS = 20
) (
  input  logic          clk,
  input  logic          rst,
  tone_player_if.slave  bus
);

  localparam int PW    = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam int GW    = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
  // One tick counter serves both PLAY and GAP, so it must hold either limit.
  localparam int CNT_W = (DUR_W > GW) ? DUR_W : GW;
  localparam int HP_W  = 17;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     presc_q, presc_d;
  logic [CNT_W-1:0]  tcnt_q, tcnt_d;
  logic [HP_W-1:0]   hcnt_q, hcnt_d;
  logic [HP_W-1:0]   hp_q, hp_d;
  logic              rest_q, rest_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic              spk_q, spk_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              accept;
  logic              tick;
  logic [CNT_W-1:0]  tcnt_nxt;
  logic              play_last;
  logic              gap_last;

  // Base half-periods in clocks at 50 MHz, round(50e6 / (2 f)).
  function automatic logic [HP_W-1:0] base_hp(input logic [3:0] n);
    logic [HP_W-1:0] r;
    unique case (n)
      4'd1:    r = 17'd95556;  // C
      4'd2:    r = 17'd90193;  // C#
      4'd3:    r = 17'd85131;  // D
      4'd4:    r = 17'd80353;  // D#
      4'd5:    r = 17'd75843;  // E
      4'd6:    r = 17'd71586;  // F
      4'd7:    r = 17'd67569;  // F#
      4'd8:    r = 17'd63776;  // G
      4'd9:    r = 17'd60197;  // G#
      4'd10:   r = 17'd56818;  // A
      4'd11:   r = 17'd53629;  // A#
      4'd12:   r = 17'd50619;  // B
      default: r = '0;         // rests
    endcase
    return r;
  endfunction

  assign tick     = (presc_q == PW'(TICK_CLKS - 1));
  assign tcnt_nxt = tcnt_q + CNT_W'(1);
  // duration 0 still gets a single PLAY clock.
  assign play_last = (dur_q == '0) || (tick && (tcnt_nxt == CNT_W'(dur_q)));
  assign gap_last  = (GAP_TICKS == 0) || (tick && (tcnt_nxt == CNT_W'(GAP_TICKS)));

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        // stop has priority over a simultaneous start.
        if (bus.start && !bus.stop) begin
          state_d = PLAY;
          accept  = 1'b1;
        end
      end
      PLAY: begin
        if (bus.stop)       state_d = IDLE;
        else if (play_last) state_d = GAP;
      end
      GAP: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else if (gap_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------- datapath
  always_comb begin
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    hcnt_d  = hcnt_q;
    spk_d   = 1'b0;
    hp_d    = hp_q;
    rest_d  = rest_q;
    dur_d   = dur_q;
    busy_d  = (state_d != IDLE);

    // Only the derived half-period and rest flag are kept; the raw note and
    // octave are not needed once the shift has been applied.
    if (accept) begin
      hp_d   = base_hp(bus.note) >> bus.octave;
      rest_d = (bus.note == 4'd0) || (bus.note > 4'd12);
      dur_d  = bus.duration;
    end

    if ((state_d != state_q) || (state_d == IDLE)) begin
      // Any state entry restarts every counter with the speaker low.
      presc_d = '0;
      tcnt_d  = '0;
      hcnt_d  = '0;
    end else begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) tcnt_d = tcnt_nxt;
      if ((state_q == PLAY) && !rest_q) begin
        if (hcnt_q == hp_q - 17'd1) begin
          hcnt_d = '0;
          spk_d  = ~spk_q;
        end else begin
          hcnt_d = hcnt_q + 17'd1;
          spk_d  = spk_q;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
      tcnt_q  <= '0;
      hcnt_q  <= '0;
      hp_q    <= '0;
      rest_q  <= 1'b0;
      dur_q   <= '0;
      spk_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      hcnt_q  <= hcnt_d;
      hp_q    <= hp_d;
      rest_q  <= rest_d;
      dur_q   <= dur_d;
      spk_q   <= spk_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.speaker = spk_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule
